// File: rtl/mdio_phy_pkg.sv
// ============================================================================
// mdio_phy_pkg : shared register map, PHY configuration ROM and FSM states
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mdio_phy_pkg;

    localparam logic [4:0] BMCR = 5'd0;
    localparam logic [4:0] BMSR = 5'd1;
    localparam logic [4:0] ANAR = 5'd4;
    localparam logic [4:0] GBCR = 5'd9;

    typedef struct packed {
        logic [4:0]  reg_addr;
        logic [15:0] data;
    } mdio_cfg_entry_t;

    localparam int CFG_LEN = 4;

    localparam mdio_cfg_entry_t CFG_ROM [CFG_LEN] = '{
        '{reg_addr: BMCR, data: 16'h1140},
        '{reg_addr: ANAR, data: 16'h01E1},
        '{reg_addr: GBCR, data: 16'h0300},
        '{reg_addr: BMCR, data: 16'h1340}
    };

    typedef enum logic [2:0] {
        POWERUP_WAIT = 3'd0,
        WR_REQ       = 3'd1,
        WR_RESP      = 3'd2,
        IDLE         = 3'd3,
        POLL_WAIT    = 3'd4,
        RD_REQ       = 3'd5,
        RD_RESP      = 3'd6,
        FAULT        = 3'd7
    } phy_init_state_t;

    // MDIO master decodes the PHY register number from a word-aligned address
    function automatic logic [31:0] reg_to_axi_addr(input logic [4:0] reg_addr);
        return {25'd0, reg_addr, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_interface.sv
// ============================================================================
// axi_lite_interface : 32-bit AXI-Lite bundle with master/slave views
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_interface;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport Master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport Slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

`default_nettype wire

// File: rtl/mdio_phy_init.sv
// ============================================================================
// mdio_phy_init : power-up wait, PHY config writes and BMSR link polling over
//                 AXI-Lite. Polling built only with MDIO_PHY_INIT_LINK_POLL_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mdio_phy_init
    import mdio_phy_pkg::*;
#(
    parameter int POWERUP_CYCLES = 125_000,
    parameter int TIMEOUT_CYCLES = 250_000,
    parameter int POLL_INTERVAL  = 12_500_000
) (
    input  logic              clk,
    input  logic              reset,
    axi_lite_interface.Master axi_lite,
    output logic              done,
    output logic              error,
    output logic              link_up
);

    localparam int CNT_MAX = (POWERUP_CYCLES > POLL_INTERVAL) ? POWERUP_CYCLES : POLL_INTERVAL;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IDX_W   = $clog2(CFG_LEN);

    phy_init_state_t    r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [TMO_W-1:0]   r_tcnt, w_tcnt_n;
    logic [IDX_W-1:0]   r_idx, w_idx_n, w_wr_idx;
    logic               r_aw_done, w_aw_done_n;
    logic               r_w_done, w_w_done_n;
    logic               r_awvalid, w_awvalid_n;
    logic               r_wvalid, w_wvalid_n;
    logic               r_bready, w_bready_n;
    logic [31:0]        r_awaddr, w_awaddr_n;
    logic [31:0]        r_wdata, w_wdata_n;
    logic               r_done, w_done_n;
    logic               r_error, w_error_n;
    logic               w_aw_hs, w_w_hs, w_b_hs, w_tmo;
    logic               w_fault, w_start_wr;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
    logic               r_rd_n, w_rd_n_n;
    logic               r_arvalid, w_arvalid_n;
    logic               r_rready, w_rready_n;
    logic [31:0]        r_araddr, w_araddr_n;
    logic               r_link_up, w_link_up_n;
    logic               w_ar_hs, w_r_hs, w_start_rd;
`endif

    assign w_aw_hs = r_awvalid & axi_lite.awready;
    assign w_w_hs  = r_wvalid & axi_lite.wready;
    assign w_b_hs  = r_bready & axi_lite.bvalid;
    assign w_tmo   = (r_tcnt == TMO_W'(TIMEOUT_CYCLES - 1));
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
    assign w_ar_hs = r_arvalid & axi_lite.arready;
    assign w_r_hs  = r_rready & axi_lite.rvalid;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_tcnt_n    = r_tcnt;
        w_idx_n     = r_idx;
        w_wr_idx    = r_idx;
        w_aw_done_n = r_aw_done;
        w_w_done_n  = r_w_done;
        w_awvalid_n = r_awvalid & ~w_aw_hs;
        w_wvalid_n  = r_wvalid & ~w_w_hs;
        w_bready_n  = r_bready;
        w_awaddr_n  = r_awaddr;
        w_wdata_n   = r_wdata;
        w_done_n    = r_done;
        w_error_n   = r_error;
        w_fault     = 1'b0;
        w_start_wr  = 1'b0;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
        w_rd_n_n    = r_rd_n;
        w_arvalid_n = r_arvalid & ~w_ar_hs;
        w_rready_n  = r_rready;
        w_araddr_n  = r_araddr;
        w_link_up_n = r_link_up;
        w_start_rd  = 1'b0;
`endif

        case (r_state)
            POWERUP_WAIT: begin
                if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                    w_state_n  = WR_REQ;
                    w_start_wr = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            WR_REQ: begin
                w_tcnt_n    = r_tcnt + 1'b1;
                w_aw_done_n = r_aw_done | w_aw_hs;
                w_w_done_n  = r_w_done | w_w_hs;
                if (w_tmo) begin
                    w_fault = 1'b1;
                end else if (w_aw_done_n && w_w_done_n) begin
                    w_state_n  = WR_RESP;
                    w_bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                w_tcnt_n = r_tcnt + 1'b1;
                // a response in the expiry cycle still counts
                if (w_b_hs) begin
                    w_bready_n = 1'b0;
                    if (axi_lite.bresp != 2'b00) begin
                        w_fault = 1'b1;
                    end else if (r_idx == IDX_W'(CFG_LEN - 1)) begin
                        w_done_n = 1'b1;
                        w_cnt_n  = '0;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
                        w_state_n = POLL_WAIT;
`else
                        w_state_n = IDLE;
`endif
                    end else begin
                        w_idx_n    = r_idx + 1'b1;
                        w_wr_idx   = r_idx + 1'b1;
                        w_state_n  = WR_REQ;
                        w_start_wr = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_fault = 1'b1;
                end
            end
            IDLE: begin
            end
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
            POLL_WAIT: begin
                if (r_cnt == CNT_W'(POLL_INTERVAL - 1)) begin
                    w_state_n  = RD_REQ;
                    w_rd_n_n   = 1'b0;
                    w_start_rd = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            RD_REQ: begin
                w_tcnt_n = r_tcnt + 1'b1;
                if (w_tmo) begin
                    w_fault = 1'b1;
                end else if (w_ar_hs) begin
                    w_state_n  = RD_RESP;
                    w_rready_n = 1'b1;
                end
            end
            RD_RESP: begin
                w_tcnt_n = r_tcnt + 1'b1;
                if (w_r_hs) begin
                    w_rready_n = 1'b0;
                    if (axi_lite.rresp != 2'b00) begin
                        w_fault = 1'b1;
                    end else if (!r_rd_n) begin
                        // first read only clears the latched-low link bit
                        w_rd_n_n   = 1'b1;
                        w_state_n  = RD_REQ;
                        w_start_rd = 1'b1;
                    end else begin
                        w_link_up_n = axi_lite.rdata[2];
                        w_cnt_n     = '0;
                        w_state_n   = POLL_WAIT;
                    end
                end else if (w_tmo) begin
                    w_fault = 1'b1;
                end
            end
`endif
            default: begin
                w_fault = 1'b1;
            end
        endcase

        if (w_start_wr) begin
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_awaddr_n  = reg_to_axi_addr(CFG_ROM[w_wr_idx].reg_addr);
            w_wdata_n   = {16'd0, CFG_ROM[w_wr_idx].data};
            w_tcnt_n    = '0;
            w_aw_done_n = 1'b0;
            w_w_done_n  = 1'b0;
        end
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
        if (w_start_rd) begin
            w_arvalid_n = 1'b1;
            w_araddr_n  = reg_to_axi_addr(BMSR);
            w_tcnt_n    = '0;
        end
`endif
        // outstanding VALIDs keep their default (drop on handshake only)
        if (w_fault) begin
            w_state_n   = FAULT;
            w_error_n   = 1'b1;
            w_bready_n  = 1'b1;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
            w_rready_n  = 1'b1;
            w_link_up_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= POWERUP_WAIT;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_idx     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
            r_rd_n    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_link_up <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_tcnt    <= w_tcnt_n;
            r_idx     <= w_idx_n;
            r_aw_done <= w_aw_done_n;
            r_w_done  <= w_w_done_n;
            r_awvalid <= w_awvalid_n;
            r_wvalid  <= w_wvalid_n;
            r_bready  <= w_bready_n;
            r_awaddr  <= w_awaddr_n;
            r_wdata   <= w_wdata_n;
            r_done    <= w_done_n;
            r_error   <= w_error_n;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
            r_rd_n    <= w_rd_n_n;
            r_arvalid <= w_arvalid_n;
            r_rready  <= w_rready_n;
            r_araddr  <= w_araddr_n;
            r_link_up <= w_link_up_n;
`endif
        end
    end

    assign axi_lite.awvalid = r_awvalid;
    assign axi_lite.awaddr  = r_awaddr;
    assign axi_lite.wvalid  = r_wvalid;
    assign axi_lite.wdata   = r_wdata;
    assign axi_lite.wstrb   = 4'hF;
    assign axi_lite.bready  = r_bready;
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
    assign axi_lite.arvalid = r_arvalid;
    assign axi_lite.araddr  = r_araddr;
    assign axi_lite.rready  = r_rready;
    assign link_up          = r_link_up;
`else
    assign axi_lite.arvalid = 1'b0;
    assign axi_lite.araddr  = '0;
    assign axi_lite.rready  = 1'b0;
    assign link_up          = 1'b0;
`endif
    assign done  = r_done;
    assign error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mdio_phy_init.sv
// ============================================================================
// tb_mdio_phy_init : randomised AXI-Lite slave with write/link scoreboards
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdio_phy_init;

    logic clk = 1'b0;
    logic reset;
    logic done, error, link_up;

    always #4 clk = ~clk;

    axi_lite_interface axi ();

    mdio_phy_init #(
        .POWERUP_CYCLES(10),
        .TIMEOUT_CYCLES(20),
        .POLL_INTERVAL (50)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .axi_lite(axi),
        .done    (done),
        .error   (error),
        .link_up (link_up)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] exp_wr[$];
    logic [31:0] rd_data_q[$];
    logic        exp_link[$];

    int   err_idx = -1;
    bit   never_awready = 1'b0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_cfg();
        exp_wr.push_back({32'h00, 32'h1140});
        exp_wr.push_back({32'h10, 32'h01E1});
        exp_wr.push_back({32'h24, 32'h0300});
        exp_wr.push_back({32'h00, 32'h1340});
    endtask

    task automatic check_reset();
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid",  axi.wvalid,  0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready",  axi.bready,  0);
        check("rst_rready",  axi.rready,  0);
        check("rst_awaddr",  axi.awaddr,  0);
        check("rst_wdata",   axi.wdata,   0);
        check("rst_araddr",  axi.araddr,  0);
        check("rst_done",    done,        0);
        check("rst_error",   error,       0);
        check("rst_link_up", link_up,     0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Slave BFM: inputs change at negedge+1, handshakes resolve at the next posedge
    initial begin : slave_bfm
        bit          aw_got, w_got, b_pend, r_pend, b_is_last, b_hs, b_hs_last, r_hs, r_second;
        int          b_dly, r_dly;
        logic [31:0] aw_addr, w_data, r_dat;
        logic [1:0]  b_resp;
        logic [63:0] e;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_is_last = 0;
        b_hs = 0; b_hs_last = 0; r_hs = 0; r_second = 0;
        b_dly = 0; r_dly = 0; aw_addr = 0; w_data = 0; r_dat = 0; b_resp = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
                axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_is_last = 0;
                b_hs = 0; b_hs_last = 0; r_hs = 0;
                wr_cnt = 0; rd_cnt = 0;
                exp_wr.delete(); rd_data_q.delete(); exp_link.delete();
            end else begin
                if (exp_link.size() > 0) check("link_up", link_up, exp_link.pop_front());
                if (b_hs) begin
                    axi.bvalid = 0;
                    if (b_hs_last) begin
                        check("done_after_last_b", done, 1);
                        check("error_after_last_b", error, 0);
                    end
                    b_hs = 0; b_hs_last = 0;
                end
                if (r_hs) begin
                    axi.rvalid = 0;
                    r_hs = 0;
                end
                if (b_pend) begin
                    if (b_dly == 0) begin
                        axi.bvalid = 1; axi.bresp = b_resp; b_pend = 0;
                    end else b_dly--;
                end
                if (r_pend) begin
                    if (r_dly == 0) begin
                        axi.rvalid = 1; axi.rdata = r_dat; axi.rresp = 0; r_pend = 0;
                    end else r_dly--;
                end
                axi.awready = never_awready ? 1'b0 : (!aw_got && ($urandom_range(0, 3) != 0));
                axi.wready  = !w_got && ($urandom_range(0, 3) != 0);
                axi.arready = ($urandom_range(0, 3) != 0);
                if (axi.awvalid && axi.awready) begin aw_got = 1; aw_addr = axi.awaddr; end
                if (axi.wvalid && axi.wready)   begin w_got = 1;  w_data = axi.wdata;   end
                if (aw_got && w_got) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", aw_addr, e[63:32]);
                        check("wr_data", w_data, e[31:0]);
                    end
                    b_resp    = (wr_cnt == err_idx) ? 2'b10 : 2'b00;
                    b_is_last = (wr_cnt == 3) && (b_resp == 2'b00);
                    b_dly     = $urandom_range(0, 2);
                    b_pend    = 1;
                    wr_cnt++;
                    aw_got = 0; w_got = 0;
                end
                if (axi.arvalid && axi.arready) begin
                    check("rd_addr", axi.araddr, 32'h04);
                    r_dat    = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'h7809;
                    r_second = rd_cnt[0];
                    r_dly    = $urandom_range(0, 2);
                    r_pend   = 1;
                    rd_cnt++;
                end
                b_hs      = axi.bvalid && axi.bready;
                b_hs_last = b_hs && b_is_last;
                r_hs      = axi.rvalid && axi.rready;
                if (r_hs && r_second) exp_link.push_back(axi.rdata[2]);
            end
        end
    end

    initial begin : main
        int n, k, busy;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();

        // power-up latency and first write
        reset = 1'b0;
        push_cfg();
`ifdef MDIO_PHY_INIT_LINK_POLL_EN
        rd_data_q.push_back(32'h7809); rd_data_q.push_back(32'h780D);
        rd_data_q.push_back(32'h7809); rd_data_q.push_back(32'h7809);
`endif
        n = 0;
        while (!axi.awvalid && n < 100) begin @(negedge clk); n++; end
        check("pwrup_lat", n, 10);
        check("first_awaddr", axi.awaddr, 32'h00);
        check("first_wdata", axi.wdata, 32'h1140);

        // full configuration sequence
        n = 0;
        while (!done && n < 1000) begin @(negedge clk); n++; end
        check("cfg_done", done, 1);
        check("cfg_error", error, 0);
        check("cfg_wr_cnt", wr_cnt, 4);

`ifdef MDIO_PHY_INIT_LINK_POLL_EN
        n = 0;
        while (rd_cnt < 4 && n < 2000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("poll_rd_cnt", rd_cnt, 4);
        check("poll_link_final", link_up, 0);
        check("poll_error", error, 0);
`else
        busy = 0;
        repeat (100) begin @(negedge clk); if (axi.arvalid || axi.rready) busy++; end
        check("idle_no_reads", busy, 0);
        check("idle_link_up", link_up, 0);
`endif

        // error response on the second write
        do_reset();
        err_idx = 1;
        reset = 1'b0;
        push_cfg();
        n = 0;
        while (!error && n < 1000) begin @(negedge clk); n++; end
        check("bresp_error", error, 1);
        check("bresp_wr_cnt", wr_cnt, 2);
        busy = 0;
        repeat (200) begin @(negedge clk); if (axi.awvalid || axi.arvalid) busy++; end
        check("fault_no_req", busy, 0);
        check("fault_done", done, 0);
        check("fault_bready", axi.bready, 1);
        check("fault_link_up", link_up, 0);
        check("fault_error_held", error, 1);

        // timeout with awready never asserted
        do_reset();
        err_idx = -1;
        never_awready = 1'b1;
        reset = 1'b0;
        push_cfg();
        n = 0;
        while (!axi.awvalid && n < 100) begin @(negedge clk); n++; end
        check("tmo_awvalid_rise", axi.awvalid, 1);
        k = 0;
        while (!error && k < 100) begin @(negedge clk); k++; end
        check("tmo_lat", k, 20);
        check("tmo_awvalid_held", axi.awvalid, 1);
        check("tmo_done", done, 0);

        // reset in the middle of a write
        do_reset();
        never_awready = 1'b0;
        reset = 1'b0;
        push_cfg();
        n = 0;
        while (!axi.wvalid && n < 100) begin @(negedge clk); n++; end
        check("mid_wvalid_seen", axi.wvalid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset();
        @(negedge clk);
        reset = 1'b0;
        push_cfg();
        n = 0;
        while (!axi.awvalid && n < 100) begin @(negedge clk); n++; end
        check("restart_lat", n, 10);
        check("restart_awaddr", axi.awaddr, 32'h00);
        check("restart_wdata", axi.wdata, 32'h1140);
        n = 0;
        while (!done && n < 1000) begin @(negedge clk); n++; end
        check("restart_done", done, 1);
        check("restart_wr_cnt", wr_cnt, 4);
        check("restart_error", error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
